// File: rtl/bus_arbiter_ctrl.sv
// Clocked round-robin bus-ownership controller wrapped around a combinational arbiter slice.
// Turns the slice's single-cycle decision into a held tenure with release, timeout and rotation.
module bus_arbiter_ctrl #(
  parameter int unsigned N        = 4,
  parameter int unsigned HOLD_MAX = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic [N-1:0] done,
  output logic [N-1:0] gnt,
  output logic         busy,
  output logic         err,
  output logic [N-1:0] arb_request,
  output logic [N-1:0] arb_rotate,
  input  logic [N-1:0] arb_grant
);

  localparam int unsigned   TW        = (HOLD_MAX == 0) ? 1 : $clog2(HOLD_MAX + 1);
  localparam bit            TimeoutEn = (HOLD_MAX != 0);
  localparam logic [TW-1:0] TimerLast = TW'((HOLD_MAX == 0) ? 0 : HOLD_MAX - 1);

  typedef enum logic [1:0] {StIdle, StOwn, StGap} state_e;

  state_e        state_q;
  logic [TW-1:0] timer_q;
  logic          grant_nonzero;
  logic          grant_one_hot;
  logic          release_own;

  assign grant_nonzero = (arb_grant != '0);
  assign grant_one_hot = grant_nonzero && ((arb_grant & (arb_grant - N'(1))) == '0);

  // gnt is one-hot in OWN, so masking with it selects the owner's bits.
  assign release_own = (|(gnt & done)) || !(|(gnt & req)) ||
                       (TimeoutEn && (timer_q == TimerLast));

  assign busy        = (state_q == StOwn);
  assign arb_request = (state_q == StIdle) ? req : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      gnt        <= '0;
      err        <= 1'b0;
      timer_q    <= '0;
      arb_rotate <= N'(1);
    end else begin
      case (state_q)
        StIdle: begin
          if (grant_one_hot) begin
            gnt     <= arb_grant;
            timer_q <= '0;
            state_q <= StOwn;
          end else if (grant_nonzero) begin
            err <= 1'b1;
          end
        end
        StOwn: begin
          if (release_own) begin
            gnt        <= '0;
            arb_rotate <= {gnt[N-2:0], gnt[N-1]};
            state_q    <= StGap;
          end else if (timer_q != '1) begin
            timer_q <= timer_q + TW'(1);
          end
        end
        StGap: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
          gnt     <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter_ctrl.sv
// Self-checking bench for bus_arbiter_ctrl: emulates the arbiter slice, runs directed
// scenarios then random traffic, comparing every cycle against an ownership-level model.
module tb_bus_arbiter_ctrl;

  localparam int unsigned N        = 4;
  localparam int unsigned HOLD_MAX = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] req;
  logic [N-1:0] done;
  logic [N-1:0] gnt;
  logic         busy;
  logic         err;
  logic [N-1:0] arb_request;
  logic [N-1:0] arb_rotate;
  logic [N-1:0] arb_grant;

  logic         force_en;
  logic [N-1:0] force_val;

  int n_assert = 0;
  int n_fail   = 0;

  // Model state: owner index (-1 when free), turnaround flag, top-priority index, tenure length.
  int m_owner;
  int m_gap;
  int m_prio;
  int m_ten;
  bit m_err;

  bus_arbiter_ctrl #(
    .N        (N),
    .HOLD_MAX (HOLD_MAX)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .done        (done),
    .gnt         (gnt),
    .busy        (busy),
    .err         (err),
    .arb_request (arb_request),
    .arb_rotate  (arb_rotate),
    .arb_grant   (arb_grant)
  );

  always #5 clk = ~clk;

  // Behavioural arbiter slice: first requester at or after the rotate bit wins.
  function automatic logic [N-1:0] slice(input logic [N-1:0] r, input logic [N-1:0] rot);
    int top = 0;
    logic [N-1:0] g = '0;
    for (int i = 0; i < N; i++) if (rot[i] === 1'b1) top = i;
    for (int k = 0; k < N; k++) begin
      int idx = (top + k) % N;
      if (r[idx] === 1'b1) begin
        g[idx] = 1'b1;
        break;
      end
    end
    return g;
  endfunction

  always_comb arb_grant = force_en ? force_val : slice(arb_request, arb_rotate);

  function automatic bit onehot(input logic [N-1:0] v);
    int c = 0;
    for (int i = 0; i < N; i++) if (v[i]) c++;
    return c == 1;
  endfunction

  task automatic model_step();
    if (reset) begin
      m_owner = -1; m_gap = 0; m_prio = 0; m_ten = 0; m_err = 1'b0;
    end else if (m_owner >= 0) begin
      if (done[m_owner] || !req[m_owner] || (HOLD_MAX != 0 && m_ten == HOLD_MAX)) begin
        m_prio  = (m_owner + 1) % N;
        m_owner = -1;
        m_gap   = 1;
      end else begin
        m_ten++;
      end
    end else if (m_gap != 0) begin
      m_gap = 0;
    end else if (force_en) begin
      if (onehot(force_val)) begin
        for (int i = 0; i < N; i++) if (force_val[i]) m_owner = i;
        m_ten = 1;
      end else if (force_val != '0) begin
        m_err = 1'b1;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        int idx = (m_prio + k) % N;
        if (req[idx]) begin
          m_owner = idx;
          m_ten   = 1;
          break;
        end
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [N-1:0] e_gnt;
    logic [N-1:0] e_rot;
    logic [N-1:0] e_req;
    e_gnt = (m_owner >= 0) ? N'(1 << m_owner) : '0;
    e_rot = N'(1 << m_prio);
    e_req = (m_owner < 0 && m_gap == 0) ? req : '0;
    check("model_gnt", 32'(gnt), 32'(e_gnt));
    check("model_busy", 32'(busy), 32'(m_owner >= 0));
    check("model_err", 32'(err), 32'(m_err));
    check("model_rotate", 32'(arb_rotate), 32'(e_rot));
    check("model_request", 32'(arb_request), 32'(e_req));
  endtask

  // One clock: inputs already driven away from the edge; sample #1 after the edge.
  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  initial begin
    m_owner = -1; m_gap = 0; m_prio = 0; m_ten = 0; m_err = 1'b0;
    reset = 1'b1; req = '0; done = '0; force_en = 1'b0; force_val = '0;
    step();
    step();
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_rotate", 32'(arb_rotate), 32'h1);

    // Priority after reset
    reset = 1'b0; req = 4'b1010;
    step();
    check("prio_gnt", 32'(gnt), 32'b0010);
    check("prio_busy", 32'(busy), 32'h1);
    check("prio_rotate", 32'(arb_rotate), 32'b0001);

    // Release by done and rotation
    done = 4'b0010;
    step();
    done = '0;
    check("rel_gap_gnt", 32'(gnt), 32'h0);
    check("rel_rotate", 32'(arb_rotate), 32'b0100);
    step();
    step();
    check("rel_next_gnt", 32'(gnt), 32'b1000);

    // Request drop by owner 3 wraps priority to bit 0
    req = 4'b0011;
    step();
    check("wrap_rotate", 32'(arb_rotate), 32'b0001);
    step();
    step();
    check("wrap_gnt", 32'(gnt), 32'b0001);

    // Timeout pre-emption
    reset = 1'b1; req = '0;
    step();
    reset = 1'b0; req = 4'b0101;
    for (int i = 0; i < int'(HOLD_MAX); i++) begin
      step();
      check("tmo_hold", 32'(gnt), 32'b0001);
    end
    step();
    check("tmo_gap", 32'(gnt), 32'h0);
    step();
    check("tmo_idle", 32'(gnt), 32'h0);
    step();
    check("tmo_next", 32'(gnt), 32'b0100);

    // Reset mid-tenure
    reset = 1'b1;
    step();
    check("mid_rst_gnt", 32'(gnt), 32'h0);
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_rotate", 32'(arb_rotate), 32'b0001);
    check("mid_rst_idle", 32'(arb_request), 32'b0101);

    // Faulty slice returns two bits
    req = '0;
    step();
    reset = 1'b0; force_en = 1'b1; force_val = 4'b0011;
    step();
    check("fault_err", 32'(err), 32'h1);
    check("fault_gnt", 32'(gnt), 32'h0);
    step();
    force_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("fault_sticky", 32'(err), 32'h1);
    end
    req = 4'b0010;
    step();
    check("fault_grant_ok", 32'(gnt), 32'b0010);
    check("fault_err_kept", 32'(err), 32'h1);
    reset = 1'b1;
    step();
    check("fault_rst_err", 32'(err), 32'h0);
    reset = 1'b0;

    // Random traffic against the model
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) req = req ^ N'(1 << $urandom_range(0, N - 1));
      done      = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
      reset     = ($urandom_range(0, 80) == 0);
      force_en  = ($urandom_range(0, 30) == 0);
      force_val = N'($urandom);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
